// File: rtl/vx_issue_warp_arbiter.sv
// Issue-stage warp arbiter: round-robin pick of a ready warp,
// one registered output slot, saturating stall counter.
module vx_issue_warp_arbiter #(
  parameter int NUM_WARPS = 4,
  parameter int DATAW     = 64,
  parameter int CTR_W     = 16,
  localparam int WIDW     = $clog2(NUM_WARPS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WARPS-1:0]       in_valid,
  input  logic [NUM_WARPS*DATAW-1:0] in_data,
  output logic [NUM_WARPS-1:0]       in_ready,
  input  logic [NUM_WARPS-1:0]       sb_ready,
  output logic                       out_valid,
  output logic [DATAW-1:0]           out_data,
  output logic [WIDW-1:0]            out_wid,
  input  logic                       out_ready,
  output logic [CTR_W-1:0]           perf_stalls
);

  logic                 out_valid_q, out_valid_d;
  logic [DATAW-1:0]     out_data_q, out_data_d;
  logic [WIDW-1:0]      out_wid_q, out_wid_d;
  logic [WIDW-1:0]      last_grant_q, last_grant_d;
  logic [CTR_W-1:0]     stalls_q, stalls_d;

  logic [NUM_WARPS-1:0] eligible;
  logic                 can_accept;
  logic                 found;
  logic                 grant_any;
  logic [WIDW-1:0]      grant_idx;
  logic [WIDW-1:0]      idx;
  logic [DATAW-1:0]     grant_data;

  // Round-robin scan starting just after the last granted warp
  always_comb begin
    eligible   = in_valid & sb_ready;
    can_accept = ~out_valid_q | out_ready;
    found      = 1'b0;
    grant_idx  = '0;
    idx        = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx = last_grant_q + WIDW'(i);
      if (!found && eligible[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    grant_any = found & can_accept;
  end

  // Payload mux and one-hot pop strobe for the chosen warp
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (grant_idx == WIDW'(w)) begin
        grant_data  = in_data[w*DATAW +: DATAW];
        in_ready[w] = grant_any & ~reset;
      end
    end
  end

  // Output slot load/drain, priority pointer and stall counter
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_wid_d    = out_wid_q;
    last_grant_d = last_grant_q;
    stalls_d     = stalls_q;
    if (grant_any) begin
      out_valid_d  = 1'b1;
      out_data_d   = grant_data;
      out_wid_d    = grant_idx;
      last_grant_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (|in_valid && !grant_any && stalls_q != {CTR_W{1'b1}}) begin
      stalls_d = stalls_q + CTR_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_wid_q    <= '0;
      last_grant_q <= '1;
      stalls_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_wid_q    <= out_wid_d;
      last_grant_q <= last_grant_d;
      stalls_q     <= stalls_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_wid     = out_wid_q;
  assign perf_stalls = stalls_q;

endmodule

// File: tb/tb_vx_issue_warp_arbiter.sv
// Directed vector bench for the issue warp arbiter,
// plus a small-counter instance for saturation.
module tb_vx_issue_warp_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   in_valid;
  logic [255:0] in_data;
  logic [3:0]   in_ready;
  logic [3:0]   sb_ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic [1:0]   out_wid;
  logic         out_ready;
  logic [15:0]  perf_stalls;

  logic         s_reset;
  logic [3:0]   s_in_valid;
  logic [31:0]  s_in_data;
  logic [3:0]   s_in_ready;
  logic [3:0]   s_sb_ready;
  logic         s_out_valid;
  logic [7:0]   s_out_data;
  logic [1:0]   s_out_wid;
  logic         s_out_ready;
  logic [3:0]   s_perf_stalls;

  int total;
  int passed;

  vx_issue_warp_arbiter #(
    .NUM_WARPS(4), .DATAW(64), .CTR_W(16)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sb_ready(sb_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_wid(out_wid), .out_ready(out_ready),
    .perf_stalls(perf_stalls)
  );

  vx_issue_warp_arbiter #(
    .NUM_WARPS(4), .DATAW(8), .CTR_W(4)
  ) u_sat (
    .clk(clk), .reset(s_reset),
    .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .sb_ready(s_sb_ready),
    .out_valid(s_out_valid), .out_data(s_out_data),
    .out_wid(s_out_wid), .out_ready(s_out_ready),
    .perf_stalls(s_perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] D0 = 64'hF000_0000_0000_00A5;
  localparam logic [63:0] D1 = 64'hE000_0000_0000_00B6;
  localparam logic [63:0] D2 = 64'hD000_0000_0000_00C7;
  localparam logic [63:0] D3 = 64'hC000_0000_0000_00D8;

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [3:0]  sb;
    logic        ordy;
    logic [3:0]  inr;
    logic        ov;
    logic [1:0]  wid;
    logic [63:0] data;
    logic [15:0] st;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [3:0] iv,
                     input logic [3:0] sb, input logic ordy,
                     input logic [3:0] inr, input logic ov,
                     input logic [1:0] wid, input logic [63:0] data,
                     input logic [15:0] st);
    vec_t v;
    v.rst = rst; v.iv = iv; v.sb = sb; v.ordy = ordy;
    v.inr = inr; v.ov = ov; v.wid = wid; v.data = data; v.st = st;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    total = 0;
    passed = 0;
    in_data = {D3, D2, D1, D0};
    reset = 1'b1; in_valid = '0; sb_ready = '0; out_ready = 1'b0;
    s_reset = 1'b1; s_in_valid = '0; s_sb_ready = '0;
    s_out_ready = 1'b1; s_in_data = 32'h44_33_22_11;

    // reset, then basic issue of warp 0
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 64'h0, 0);
    add(0, 4'b0001, 4'b1111, 1, 4'b0001, 1, 0, D0, 0);
    // reset with a would-be grant pending: strobe must stay low
    add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 64'h0, 0);
    // round robin, no bubbles
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, D0, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, D1, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2, D2, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 3, D3, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, D0, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, D1, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2, D2, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 3, D3, 0);
    // bring last_grant to 0
    add(0, 4'b0001, 4'b1111, 1, 4'b0001, 1, 0, D0, 0);
    // scoreboard skips warp 1
    add(0, 4'b0110, 4'b0100, 1, 4'b0100, 1, 2, D2, 0);
    // fully blocked: slot drains, counter climbs
    add(0, 4'b0110, 4'b0000, 1, 4'b0000, 0, 2, D2, 1);
    add(0, 4'b0110, 4'b0000, 1, 4'b0000, 0, 2, D2, 2);
    add(0, 4'b0110, 4'b0000, 1, 4'b0000, 0, 2, D2, 3);
    add(0, 4'b0110, 4'b0000, 1, 4'b0000, 0, 2, D2, 4);
    add(0, 4'b0110, 4'b0000, 1, 4'b0000, 0, 2, D2, 5);
    // load warp 1, then backpressure for 3 cycles
    add(0, 4'b0010, 4'b1111, 1, 4'b0010, 1, 1, D1, 5);
    add(0, 4'b1111, 4'b1111, 0, 4'b0000, 1, 1, D1, 6);
    add(0, 4'b1111, 4'b1111, 0, 4'b0000, 1, 1, D1, 7);
    add(0, 4'b1111, 4'b1111, 0, 4'b0000, 1, 1, D1, 8);
    // release: warp 2 replaces warp 1 in the same cycle
    add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2, D2, 8);
    // reset mid-operation, then priority back to warp 0
    add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 64'h0, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, D0, 0);
    // nothing valid: drain without counting a stall
    add(0, 4'b0000, 4'b1111, 1, 4'b0000, 0, 0, D0, 0);

    @(posedge clk);
    #1;
    foreach (vq[i]) begin
      reset     = vq[i].rst;
      in_valid  = vq[i].iv;
      sb_ready  = vq[i].sb;
      out_ready = vq[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), 64'(in_ready),
            64'(vq[i].inr));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 64'(out_valid),
            64'(vq[i].ov));
      check($sformatf("v%0d out_wid", i), 64'(out_wid),
            64'(vq[i].wid));
      check($sformatf("v%0d out_data", i), out_data, vq[i].data);
      check($sformatf("v%0d perf_stalls", i), 64'(perf_stalls),
            64'(vq[i].st));
    end

    // saturation on the 4-bit counter instance
    reset = 1'b1;
    s_reset = 1'b1;
    @(posedge clk);
    #1;
    s_reset = 1'b0;
    s_in_valid = 4'b0001;
    s_sb_ready = 4'b0000;
    for (int k = 1; k <= 20; k++) begin
      #1;
      check($sformatf("sat%0d in_ready", k), 64'(s_in_ready), 64'h0);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d perf_stalls", k), 64'(s_perf_stalls),
            64'((k > 15) ? 15 : k));
    end
    check("sat out_valid", 64'(s_out_valid), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
